// File: rtl/onchip_dpram_pkg.sv
// Shared types and helpers for the dual-port Avalon-MM on-chip RAM.
package onchip_dpram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

  // Write enable for one s2 byte lane when both ports may hit the same word:
  // s1 owns any lane that both ports enable, s2 keeps the lanes only it enables.
  function automatic logic be_merge(input logic be1Lane, input logic be2Lane,
                                    input logic sameWord);
    return be2Lane & ~(sameWord & be1Lane);
  endfunction

endpackage

// File: rtl/onchip_dpram_core.sv
// True-dual-port byte-enabled RAM array, one clock, shared clock enable.
// Each port reads the word as it was before this edge's writes (old data).
module onchip_dpram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    i_ce,
  input  logic [IDX_W-1:0]        i_addrA,
  input  logic [DATA_WIDTH/8-1:0] i_weA,
  input  logic [DATA_WIDTH-1:0]   i_dataA,
  output logic [DATA_WIDTH-1:0]   o_qA,
  input  logic [IDX_W-1:0]        i_addrB,
  input  logic [DATA_WIDTH/8-1:0] i_weB,
  input  logic [DATA_WIDTH-1:0]   i_dataB,
  output logic [DATA_WIDTH-1:0]   o_qB
);

  localparam int BE_W = DATA_WIDTH / 8;

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_qA;
  logic [DATA_WIDTH-1:0] r_qB;

  // Registered reads of the pre-write contents plus per-lane writes on both ports.
  always_ff @(posedge clk) begin
    if (i_ce) begin
      r_qA <= r_mem[i_addrA];
      r_qB <= r_mem[i_addrB];
      for (int i = 0; i < BE_W; i++) begin
        if (i_weA[i]) r_mem[i_addrA][i*8 +: 8] <= i_dataA[i*8 +: 8];
        if (i_weB[i]) r_mem[i_addrB][i*8 +: 8] <= i_dataB[i*8 +: 8];
      end
    end
  end

  assign o_qA = r_qA;
  assign o_qB = r_qB;

endmodule

// File: rtl/onchip_dpram_avmm.sv
// Two Avalon-MM slave ports onto a dual-port RAM, with a clear engine,
// collision masking, range checking and a 1- or 2-cycle read pipeline.
module onchip_dpram_avmm
  import onchip_dpram_pkg::*;
#(
  parameter int                   DATA_WIDTH     = BE_WIDTH * 8,
  parameter int                   DEPTH          = 24576,
  parameter int                   ADDR_WIDTH     = 15,
  parameter int                   READ_LATENCY   = 1,
  parameter int                   CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  parameter                       INIT_FILE      = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    init_start,
  output logic                    init_busy,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic                    chipselect2,
  input  logic                    read2,
  input  logic                    write2,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid2,
  output logic                    waitrequest2,
  output logic [1:0]              range_err
);

  localparam int                    BE_W      = DATA_WIDTH / 8;
  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_clrAddr;
  logic                  r_v1A, r_v1B, r_oorA, r_oorB;
  logic [1:0]            r_rangeErr;

  logic                  w_clearing, w_stall;
  logic                  w_acc1, w_acc2, w_wr1, w_wr2, w_rd1, w_rd2;
  logic                  w_in1, w_in2, w_same;
  logic [BE_W-1:0]       w_weUser1, w_weA, w_weB;
  logic [IDX_W-1:0]      w_addrA;
  logic [DATA_WIDTH-1:0] w_dataA, w_qA, w_qB, w_s1DataA, w_s1DataB;

  assign w_clearing  = (r_state == ST_CLEAR);
  assign init_busy   = w_clearing;
  assign w_stall     = reset | reset_req | w_clearing | init_start;
  assign waitrequest  = w_stall;
  assign waitrequest2 = w_stall;

  assign w_acc1 = chipselect  & (read  | write)  & ~w_stall;
  assign w_acc2 = chipselect2 & (read2 | write2) & ~w_stall;
  assign w_wr1  = w_acc1 & write;
  assign w_wr2  = w_acc2 & write2;
  assign w_rd1  = w_acc1 & read  & ~write;
  assign w_rd2  = w_acc2 & read2 & ~write2;
  assign w_in1  = ({1'b0, address}  < DEPTH_LIM);
  assign w_in2  = ({1'b0, address2} < DEPTH_LIM);
  assign w_same = w_wr1 & w_wr2 & w_in1 & w_in2 & (address == address2);

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign w_weUser1[i] = w_wr1 & w_in1 & byteenable[i];
    assign w_weB[i]     = w_wr2 & w_in2 & be_merge(byteenable[i], byteenable2[i], w_same);
  end

  assign w_weA   = (w_clearing & ~reset) ? {BE_W{1'b1}} : w_weUser1;
  assign w_addrA = w_clearing ? r_clrAddr : address[IDX_W-1:0];
  assign w_dataA = w_clearing ? INIT_VALUE : writedata;

  onchip_dpram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clk    (clk),
    .i_ce   (~reset_req),
    .i_addrA(w_addrA),
    .i_weA  (w_weA),
    .i_dataA(w_dataA),
    .o_qA   (w_qA),
    .i_addrB(address2[IDX_W-1:0]),
    .i_weB  (w_weB),
    .i_dataB(writedata2),
    .o_qB   (w_qB)
  );

  // Clear/run state machine; the clear walks every word once, freeze holds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      r_clrAddr <= '0;
    end else if (!reset_req) begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clrAddr == LAST_IDX) begin
            r_state   <= ST_RUN;
            r_clrAddr <= '0;
          end else begin
            r_clrAddr <= r_clrAddr + IDX_W'(1);
          end
        end
        ST_RUN: begin
          if (init_start) begin
            r_state   <= ST_CLEAR;
            r_clrAddr <= '0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // First read stage tracks valid and out-of-range alongside the RAM output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1A <= 1'b0;
      r_v1B <= 1'b0;
      r_oorA <= 1'b0;
      r_oorB <= 1'b0;
    end else if (!reset_req) begin
      r_v1A <= w_rd1;
      r_v1B <= w_rd2;
      r_oorA <= ~w_in1;
      r_oorB <= ~w_in2;
    end
  end

  // Range error is a one-cycle pulse per accepted out-of-range access.
  always_ff @(posedge clk) begin
    if (reset) r_rangeErr <= 2'b00;
    else       r_rangeErr <= {w_acc2 & ~w_in2, w_acc1 & ~w_in1};
  end

  assign range_err = r_rangeErr;
  assign w_s1DataA = (r_v1A & ~r_oorA) ? w_qA : '0;
  assign w_s1DataB = (r_v1B & ~r_oorB) ? w_qB : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_v2A, r_v2B;
    logic [DATA_WIDTH-1:0] r_rdA, r_rdB;

    // Optional output register stage, frozen together with the RAM.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_v2A <= 1'b0;
        r_v2B <= 1'b0;
        r_rdA <= '0;
        r_rdB <= '0;
      end else if (!reset_req) begin
        r_v2A <= r_v1A;
        r_v2B <= r_v1B;
        r_rdA <= w_s1DataA;
        r_rdB <= w_s1DataB;
      end
    end

    assign readdata       = r_rdA;
    assign readdata2      = r_rdB;
    assign readdatavalid  = r_v2A & ~reset_req;
    assign readdatavalid2 = r_v2B & ~reset_req;
  end else begin : g_lat1
    assign readdata       = w_s1DataA;
    assign readdata2      = w_s1DataB;
    assign readdatavalid  = r_v1A & ~reset_req;
    assign readdatavalid2 = r_v1B & ~reset_req;
  end

endmodule

// File: tb/tb_onchip_dpram_avmm.sv
// Directed bench: instance A (64 words, latency 1, clear on reset) and
// instance B (24576 words, latency 2, no clear on reset).
module tb_onchip_dpram_avmm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset[2], resetReq[2], initStart[2], initBusy[2];
  logic [1:0]  rangeErr[2];
  logic        cs[2][2], rd[2][2], wr[2][2], rv[2][2], wreq[2][2];
  logic [14:0] addr[2][2];
  logic [3:0]  be[2][2];
  logic [31:0] wd[2][2], rdata[2][2];

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    int          inst;
    int          port;
    bit          isWr;
    logic [14:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] expData;
    logic [1:0]  expRange;
  } vec_t;

  onchip_dpram_avmm #(
    .DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(15), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1), .INIT_VALUE(32'hA5A5A5A5), .INIT_FILE("")
  ) dutA (
    .clk(clk), .reset(reset[0]), .reset_req(resetReq[0]),
    .init_start(initStart[0]), .init_busy(initBusy[0]),
    .chipselect(cs[0][0]), .read(rd[0][0]), .write(wr[0][0]),
    .address(addr[0][0]), .byteenable(be[0][0]), .writedata(wd[0][0]),
    .readdata(rdata[0][0]), .readdatavalid(rv[0][0]), .waitrequest(wreq[0][0]),
    .chipselect2(cs[0][1]), .read2(rd[0][1]), .write2(wr[0][1]),
    .address2(addr[0][1]), .byteenable2(be[0][1]), .writedata2(wd[0][1]),
    .readdata2(rdata[0][1]), .readdatavalid2(rv[0][1]), .waitrequest2(wreq[0][1]),
    .range_err(rangeErr[0])
  );

  onchip_dpram_avmm #(
    .DATA_WIDTH(32), .DEPTH(24576), .ADDR_WIDTH(15), .READ_LATENCY(2),
    .CLEAR_ON_RESET(0), .INIT_VALUE(32'h0), .INIT_FILE("")
  ) dutB (
    .clk(clk), .reset(reset[1]), .reset_req(resetReq[1]),
    .init_start(initStart[1]), .init_busy(initBusy[1]),
    .chipselect(cs[1][0]), .read(rd[1][0]), .write(wr[1][0]),
    .address(addr[1][0]), .byteenable(be[1][0]), .writedata(wd[1][0]),
    .readdata(rdata[1][0]), .readdatavalid(rv[1][0]), .waitrequest(wreq[1][0]),
    .chipselect2(cs[1][1]), .read2(rd[1][1]), .write2(wr[1][1]),
    .address2(addr[1][1]), .byteenable2(be[1][1]), .writedata2(wd[1][1]),
    .readdata2(rdata[1][1]), .readdatavalid2(rv[1][1]), .waitrequest2(wreq[1][1]),
    .range_err(rangeErr[1])
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic idlePort(input int k, input int p);
    cs[k][p] = 1'b0;
    rd[k][p] = 1'b0;
    wr[k][p] = 1'b0;
  endtask

  // One single-port transaction; returns range_err seen after acceptance and,
  // for reads, the data/valid at the cycle the latency says they appear.
  task automatic applyStimulus(input int k, input int p, input bit isWr,
                               input logic [14:0] a, input logic [3:0] b,
                               input logic [31:0] d, output logic [31:0] rdOut,
                               output logic rvOut, output logic [1:0] rngOut);
    int guard;
    int lat;
    guard = 0;
    lat = (k == 0) ? 1 : 2;
    cs[k][p] = 1'b1;
    rd[k][p] = !isWr;
    wr[k][p] = isWr;
    addr[k][p] = a;
    be[k][p] = b;
    wd[k][p] = d;
    #1;
    while (wreq[k][p] && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) checkOutput("waitrequest timeout", 32'(wreq[k][p]), 32'd0);
    tick();
    rngOut = rangeErr[k];
    idlePort(k, p);
    rdOut = '0;
    rvOut = 1'b0;
    if (!isWr) begin
      repeat (lat - 1) tick();
      rdOut = rdata[k][p];
      rvOut = rv[k][p];
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs[19];
    logic [31:0] rdv;
    logic        rvv;
    logic [1:0]  rng;
    int          cnt;
    int          issued;
    int          got;
    bit          acc;
    bit          expV;

    vecs[0]  = '{0, 0, 1'b0, 15'd0,     4'hF,    32'h0,        32'hA5A5A5A5, 2'b00};
    vecs[1]  = '{0, 1, 1'b0, 15'd0,     4'hF,    32'h0,        32'hA5A5A5A5, 2'b00};
    vecs[2]  = '{0, 0, 1'b0, 15'd63,    4'hF,    32'h0,        32'hA5A5A5A5, 2'b00};
    vecs[3]  = '{0, 1, 1'b0, 15'd63,    4'hF,    32'h0,        32'hA5A5A5A5, 2'b00};
    vecs[4]  = '{0, 0, 1'b1, 15'd10,    4'hF,    32'hFFFF0000, 32'h0,        2'b00};
    vecs[5]  = '{0, 1, 1'b0, 15'd10,    4'hF,    32'h0,        32'hFFFF0000, 2'b00};
    vecs[6]  = '{0, 1, 1'b1, 15'd11,    4'b0101, 32'h12345678, 32'h0,        2'b00};
    vecs[7]  = '{0, 0, 1'b0, 15'd11,    4'hF,    32'h0,        32'hA534A578, 2'b00};
    vecs[8]  = '{0, 0, 1'b1, 15'd64,    4'hF,    32'h0,        32'h0,        2'b01};
    vecs[9]  = '{0, 1, 1'b0, 15'd64,    4'hF,    32'h0,        32'h0,        2'b10};
    vecs[10] = '{0, 0, 1'b0, 15'd0,     4'hF,    32'h0,        32'hA5A5A5A5, 2'b00};
    vecs[11] = '{1, 0, 1'b1, 15'd8216,  4'hF,    32'hCAFE0001, 32'h0,        2'b00};
    vecs[12] = '{1, 0, 1'b1, 15'd24,    4'hF,    32'hCAFE0002, 32'h0,        2'b00};
    vecs[13] = '{1, 0, 1'b1, 15'd24575, 4'hF,    32'hCAFE0003, 32'h0,        2'b00};
    vecs[14] = '{1, 0, 1'b1, 15'd24600, 4'hF,    32'hDEADBEEF, 32'h0,        2'b01};
    vecs[15] = '{1, 0, 1'b0, 15'd24600, 4'hF,    32'h0,        32'h0,        2'b01};
    vecs[16] = '{1, 0, 1'b0, 15'd8216,  4'hF,    32'h0,        32'hCAFE0001, 2'b00};
    vecs[17] = '{1, 1, 1'b0, 15'd24,    4'hF,    32'h0,        32'hCAFE0002, 2'b00};
    vecs[18] = '{1, 0, 1'b0, 15'd24575, 4'hF,    32'h0,        32'hCAFE0003, 2'b00};

    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      resetReq[k] = 1'b0;
      initStart[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        idlePort(k, p);
        addr[k][p] = '0;
        be[k][p] = '0;
        wd[k][p] = '0;
      end
    end

    // Reset values, then the reset-triggered clear on instance A.
    repeat (3) tick();
    checkOutput("A reset readdata", rdata[0][0], 32'h0);
    checkOutput("A reset readdata2", rdata[0][1], 32'h0);
    checkOutput("A reset valid", {30'd0, rv[0][1], rv[0][0]}, 32'h0);
    checkOutput("A reset range_err", 32'(rangeErr[0]), 32'h0);
    checkOutput("A reset init_busy", 32'(initBusy[0]), 32'd1);
    checkOutput("B reset init_busy", 32'(initBusy[1]), 32'd0);
    checkOutput("B reset readdata", rdata[1][0], 32'h0);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    #1;
    checkOutput("B waitrequest after reset", 32'(wreq[1][0]), 32'd0);
    checkOutput("A waitrequest2 after reset", 32'(wreq[0][1]), 32'd1);
    cnt = 0;
    while (wreq[0][0] && cnt < 200) begin
      cnt++;
      tick();
    end
    checkOutput("A clear waitrequest cycles", cnt, 32'd64);

    // Table-driven single transactions.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].inst, vecs[i].port, vecs[i].isWr, vecs[i].a,
                    vecs[i].b, vecs[i].d, rdv, rvv, rng);
      checkOutput($sformatf("vec%0d range_err", i), 32'(rng), 32'(vecs[i].expRange));
      if (!vecs[i].isWr) begin
        checkOutput($sformatf("vec%0d valid", i), 32'(rvv), 32'd1);
        checkOutput($sformatf("vec%0d data", i), rdv, vecs[i].expData);
      end
    end

    // Range error is a single-cycle pulse.
    applyStimulus(1, 0, 1'b1, 15'd24600, 4'hF, 32'h0, rdv, rvv, rng);
    checkOutput("B range_err pulse", 32'(rng), 32'd1);
    tick();
    checkOutput("B range_err pulse end", 32'(rangeErr[1]), 32'd0);

    // Write/write collision on address 5.
    cs[0][0] = 1; wr[0][0] = 1; addr[0][0] = 15'd5; be[0][0] = 4'b0011; wd[0][0] = 32'h11223344;
    cs[0][1] = 1; wr[0][1] = 1; addr[0][1] = 15'd5; be[0][1] = 4'b0110; wd[0][1] = 32'hAABBCCDD;
    tick();
    idlePort(0, 0);
    idlePort(0, 1);
    applyStimulus(0, 0, 1'b0, 15'd5, 4'hF, 32'h0, rdv, rvv, rng);
    checkOutput("collision s1 read", rdv, 32'hA5BB3344);
    applyStimulus(0, 1, 1'b0, 15'd5, 4'hF, 32'h0, rdv, rvv, rng);
    checkOutput("collision s2 read", rdv, 32'hA5BB3344);

    // Mixed-port read during write returns old data.
    applyStimulus(0, 0, 1'b1, 15'd9, 4'hF, 32'h0, rdv, rvv, rng);
    cs[0][0] = 1; wr[0][0] = 1; addr[0][0] = 15'd9; be[0][0] = 4'hF; wd[0][0] = 32'hDEADBEEF;
    cs[0][1] = 1; rd[0][1] = 1; addr[0][1] = 15'd9; be[0][1] = 4'hF;
    tick();
    idlePort(0, 0);
    idlePort(0, 1);
    checkOutput("old-data valid", 32'(rv[0][1]), 32'd1);
    checkOutput("old-data read", rdata[0][1], 32'h0);
    applyStimulus(0, 1, 1'b0, 15'd9, 4'hF, 32'h0, rdv, rvv, rng);
    checkOutput("new-data read", rdv, 32'hDEADBEEF);

    // Read in flight when a clear starts, then reset at clr_addr 30.
    cs[0][0] = 1; rd[0][0] = 1; addr[0][0] = 15'd5;
    tick();
    rd[0][0] = 0; wr[0][0] = 1; addr[0][0] = 15'd12; wd[0][0] = 32'h0; be[0][0] = 4'hF;
    initStart[0] = 1'b1;
    #1;
    checkOutput("in-flight valid", 32'(rv[0][0]), 32'd1);
    checkOutput("in-flight data", rdata[0][0], 32'hA5BB3344);
    checkOutput("init_start blocks command", 32'(wreq[0][0]), 32'd1);
    tick();
    initStart[0] = 1'b0;
    idlePort(0, 0);
    checkOutput("init_busy after start", 32'(initBusy[0]), 32'd1);
    repeat (30) tick();
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    cnt = 0;
    while (initBusy[0] && cnt < 200) begin
      initStart[0] = (cnt == 10);
      cnt++;
      tick();
    end
    initStart[0] = 1'b0;
    checkOutput("restarted clear length", cnt, 32'd64);
    applyStimulus(0, 0, 1'b0, 15'd5, 4'hF, 32'h0, rdv, rvv, rng);
    checkOutput("cleared addr 5", rdv, 32'hA5A5A5A5);
    applyStimulus(0, 1, 1'b0, 15'd9, 4'hF, 32'h0, rdv, rvv, rng);
    checkOutput("cleared addr 9", rdv, 32'hA5A5A5A5);
    applyStimulus(0, 1, 1'b0, 15'd12, 4'hF, 32'h0, rdv, rvv, rng);
    checkOutput("blocked write addr 12", rdv, 32'hA5A5A5A5);

    // Latency-2 stream of eight reads with a three-cycle freeze.
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 0, 1'b1, 15'(i), 4'hF, 32'h10000000 + 32'(i), rdv, rvv, rng);
    issued = 0;
    got = 0;
    for (int c = 0; c < 16; c++) begin
      resetReq[1] = (c >= 4 && c < 7);
      if (issued < 8) begin
        cs[1][0] = 1; rd[1][0] = 1; wr[1][0] = 0; addr[1][0] = 15'(issued); be[1][0] = 4'hF;
      end else begin
        idlePort(1, 0);
      end
      acc = (issued < 8) && !resetReq[1];
      #1;
      expV = (c == 2 || c == 3 || (c >= 7 && c <= 12));
      checkOutput($sformatf("stream valid c%0d", c), 32'(rv[1][0]), 32'(expV));
      if (rv[1][0]) begin
        if (got < 8)
          checkOutput($sformatf("stream word %0d", got), rdata[1][0], 32'h10000000 + 32'(got));
        got++;
      end
      tick();
      if (acc) issued++;
    end
    resetReq[1] = 1'b0;
    idlePort(1, 0);
    checkOutput("stream count", got, 32'd8);

    // Reset flushes a pending latency-2 read.
    cs[1][0] = 1; rd[1][0] = 1; addr[1][0] = 15'd3;
    tick();
    idlePort(1, 0);
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    checkOutput("flush valid 0", 32'(rv[1][0]), 32'd0);
    tick();
    checkOutput("flush valid 1", 32'(rv[1][0]), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
